// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store initiator:
//   - lsu_state_e  : initiator FSM state encoding
//   - F3_*         : RV32I load/store funct3 codes
//   - SIGN_MASK_*  : data_mem sign_mask encodings
//                    bit3 = sign-extend, [2:0] = size (001 byte, 011 half, 111 word)
//   - lsu_size_of  : helper returning the access size class of a funct3
// ---------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // RV32I funct3 codes (loads use all five, stores use B/H/W only)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // data_mem sign_mask encodings
  localparam logic [3:0] SIGN_MASK_B  = 4'b1001;  // signed byte
  localparam logic [3:0] SIGN_MASK_H  = 4'b1011;  // signed half
  localparam logic [3:0] SIGN_MASK_W  = 4'b0111;  // word
  localparam logic [3:0] SIGN_MASK_BU = 4'b0001;  // unsigned byte / store byte
  localparam logic [3:0] SIGN_MASK_HU = 4'b0011;  // unsigned half / store half

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } lsu_size_e;

  // funct3[1:0] carries the size for every legal load/store encoding.
  function automatic lsu_size_e lsu_size_of(input logic [2:0] funct3);
    lsu_size_e sz;
    case (funct3[1:0])
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      2'b10:   sz = SZ_WORD;
      default: sz = SZ_NONE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// ---------------------------------------------------------------------------
// Interfaces for lsu_mem_initiator.
//   lsu_core_if : pipeline-side request/response channel (valid/ready both ways)
//     master = core pipeline, slave = initiator
//     req_valid/req_we/req_funct3/req_addr/req_wdata/rsp_ready : master -> slave
//     req_ready/rsp_valid/rsp_data/rsp_err                    : slave  -> master
//   lsu_mem_if  : data_mem-side bus
//     master = initiator, slave = data_mem
//     mem_addr/mem_write_data/mem_memwrite/mem_memread/mem_sign_mask : master -> slave
//     mem_read_data/mem_clk_stall                                    : slave  -> master
// ---------------------------------------------------------------------------
interface lsu_core_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

interface lsu_mem_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;

  modport master (
    output mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask,
    input  mem_read_data, mem_clk_stall
  );

  modport slave (
    input  mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask,
    output mem_read_data, mem_clk_stall
  );
endinterface

// File: rtl/lsu_mask_decode.sv
// ---------------------------------------------------------------------------
// lsu_mask_decode
// Purely combinational translation of an RV32I load/store into data_mem's
// sign_mask encoding, plus legality and natural-alignment flags.
// Ports:
//   i_we          in  1  1 = store, 0 = load
//   i_funct3      in  3  RV32I funct3
//   i_addr_lo     in  2  byte address bits [1:0]
//   o_sign_mask   out 4  data_mem sign_mask (0 when illegal)
//   o_illegal     out 1  funct3 not a legal load/store for i_we
//   o_misaligned  out 1  half with addr[0]!=0 or word with addr[1:0]!=0
// ---------------------------------------------------------------------------
module lsu_mask_decode
  import lsu_pkg::*;
(
  input  logic       i_we,
  input  logic [2:0] i_funct3,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_sign_mask,
  output logic       o_illegal,
  output logic       o_misaligned
);

  lsu_size_e w_size;

  assign w_size = lsu_size_of(i_funct3);

  always_comb begin
    o_sign_mask = 4'b0000;
    o_illegal   = 1'b0;
    if (i_we) begin
      // stores never sign-extend, so only the size bits matter
      case (i_funct3)
        F3_B:    o_sign_mask = SIGN_MASK_BU;
        F3_H:    o_sign_mask = SIGN_MASK_HU;
        F3_W:    o_sign_mask = SIGN_MASK_W;
        default: o_illegal   = 1'b1;
      endcase
    end else begin
      case (i_funct3)
        F3_B:    o_sign_mask = SIGN_MASK_B;
        F3_H:    o_sign_mask = SIGN_MASK_H;
        F3_W:    o_sign_mask = SIGN_MASK_W;
        F3_BU:   o_sign_mask = SIGN_MASK_BU;
        F3_HU:   o_sign_mask = SIGN_MASK_HU;
        default: o_illegal   = 1'b1;
      endcase
    end
  end

  always_comb begin
    o_misaligned = 1'b0;
    case (w_size)
      SZ_HALF: o_misaligned = i_addr_lo[0];
      SZ_WORD: o_misaligned = |i_addr_lo;
      default: o_misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// ---------------------------------------------------------------------------
// lsu_mem_initiator
// Load/store initiator between the core pipeline and data_mem. Accepts one
// request at a time, issues a single-cycle memread/memwrite strobe, waits
// while data_mem holds clk_stall, and returns load data or a store ack.
// FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE (illegal requests IDLE -> RESP).
// Parameters:
//   STALL_TIMEOUT  stalled WAIT cycles tolerated before aborting with rsp_err
//   CNT_W          watchdog width, 2**CNT_W must exceed STALL_TIMEOUT
// Ports:
//   clk    in  core clock, all state on the rising edge
//   rst_n  in  asynchronous active-low reset
//   core   lsu_core_if.slave  request/response channel to the pipeline
//   mem    lsu_mem_if.master  bus to data_mem
// Configuration macro:
//   LSU_MISALIGN_CHECK_EN  when defined, misaligned half/word accesses are
//                          rejected in IDLE with rsp_err and no strobe.
// ---------------------------------------------------------------------------
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int STALL_TIMEOUT = 255,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_core_if.slave  core,
  lsu_mem_if.master  mem
);

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MISALIGN_CHECK = 1'b1;
`else
  localparam bit MISALIGN_CHECK = 1'b0;
`endif

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(STALL_TIMEOUT);

  // state
  lsu_state_e       r_state;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_mask;
  logic             r_we;
  logic             r_memread;
  logic             r_memwrite;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_cnt;

  // next-state
  lsu_state_e       w_state_next;
  logic [31:0]      w_addr_next;
  logic [31:0]      w_wdata_next;
  logic [3:0]       w_mask_next;
  logic             w_we_next;
  logic             w_memread_next;
  logic             w_memwrite_next;
  logic [31:0]      w_rsp_data_next;
  logic             w_rsp_err_next;
  logic [CNT_W-1:0] w_cnt_next;

  // decode of the incoming request
  logic [3:0]       w_dec_mask;
  logic             w_dec_illegal;
  logic             w_dec_misaligned;
  logic             w_reject;
  logic [CNT_W-1:0] w_cnt_inc;

  lsu_mask_decode u_mask_decode (
    .i_we         (core.req_we),
    .i_funct3     (core.req_funct3),
    .i_addr_lo    (core.req_addr[1:0]),
    .o_sign_mask  (w_dec_mask),
    .o_illegal    (w_dec_illegal),
    .o_misaligned (w_dec_misaligned)
  );

  assign w_reject  = w_dec_illegal | (MISALIGN_CHECK & w_dec_misaligned);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_mask     <= 4'd0;
      r_we       <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_rsp_data <= 32'd0;
      r_rsp_err  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_addr     <= w_addr_next;
      r_wdata    <= w_wdata_next;
      r_mask     <= w_mask_next;
      r_we       <= w_we_next;
      r_memread  <= w_memread_next;
      r_memwrite <= w_memwrite_next;
      r_rsp_data <= w_rsp_data_next;
      r_rsp_err  <= w_rsp_err_next;
      r_cnt      <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_addr_next     = r_addr;
    w_wdata_next    = r_wdata;
    w_mask_next     = r_mask;
    w_we_next       = r_we;
    // strobes are only ever raised for the single ISSUE cycle
    w_memread_next  = 1'b0;
    w_memwrite_next = 1'b0;
    w_rsp_data_next = r_rsp_data;
    w_rsp_err_next  = r_rsp_err;
    w_cnt_next      = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (core.req_valid) begin
          w_rsp_data_next = 32'd0;
          if (w_reject) begin
            // rejected requests never touch the memory bus
            w_rsp_err_next = 1'b1;
            w_state_next   = ST_RESP;
          end else begin
            w_addr_next     = core.req_addr;
            w_wdata_next    = core.req_wdata;
            w_mask_next     = w_dec_mask;
            w_we_next       = core.req_we;
            w_memread_next  = ~core.req_we;
            w_memwrite_next = core.req_we;
            w_rsp_err_next  = 1'b0;
            w_state_next    = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        w_cnt_next   = '0;
        w_state_next = ST_WAIT;
      end

      ST_WAIT: begin
        if (!mem.mem_clk_stall) begin
          w_rsp_data_next = r_we ? 32'd0 : mem.mem_read_data;
          w_rsp_err_next  = 1'b0;
          w_state_next    = ST_RESP;
        end else if (w_cnt_inc == TIMEOUT_VAL) begin
          w_rsp_data_next = 32'd0;
          w_rsp_err_next  = 1'b1;
          w_cnt_next      = w_cnt_inc;
          w_state_next    = ST_RESP;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      ST_RESP: begin
        if (core.rsp_ready) begin
          w_rsp_data_next = 32'd0;
          w_rsp_err_next  = 1'b0;
          w_state_next    = ST_IDLE;
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  assign core.req_ready = (r_state == ST_IDLE);
  assign core.rsp_valid = (r_state == ST_RESP);
  assign core.rsp_data  = r_rsp_data;
  assign core.rsp_err   = r_rsp_err;

  assign mem.mem_addr       = r_addr;
  assign mem.mem_write_data = r_wdata;
  assign mem.mem_sign_mask  = r_mask;
  assign mem.mem_memread    = r_memread;
  assign mem.mem_memwrite   = r_memwrite;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_initiator
// Directed bench for lsu_mem_initiator (STALL_TIMEOUT = 8). The memory side
// is driven by hand: mem_clk_stall and mem_read_data are set per step, and
// mem_read_data is the already-extended value data_mem would return.
// Inputs change and outputs are observed on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_lsu_mem_initiator;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  lsu_core_if core_if ();
  lsu_mem_if  mem_if ();

  lsu_mem_initiator #(
    .STALL_TIMEOUT (8),
    .CNT_W         (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .core  (core_if.slave),
    .mem   (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request for exactly one cycle; returns on the falling edge
  // after the accepting rising edge.
  task automatic send(input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata);
    core_if.req_we     = we;
    core_if.req_funct3 = f3;
    core_if.req_addr   = addr;
    core_if.req_wdata  = wdata;
    core_if.req_valid  = 1'b1;
    tick();
    core_if.req_valid  = 1'b0;
    $display("req we=%0d f3=%03b addr=%h wdata=%h", we, f3, addr, wdata);
  endtask

  // Complete the response handshake and confirm return to IDLE.
  task automatic finish_rsp(input string tag);
    core_if.rsp_ready = 1'b1;
    tick();
    core_if.rsp_ready = 1'b0;
    check({tag, "_rsp_valid_drop"}, 32'(core_if.rsp_valid), 32'd0);
    check({tag, "_ready_idle"},     32'(core_if.req_ready), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    core_if.req_valid  = 1'b0;
    core_if.req_we     = 1'b0;
    core_if.req_funct3 = 3'b000;
    core_if.req_addr   = 32'd0;
    core_if.req_wdata  = 32'd0;
    core_if.rsp_ready  = 1'b0;
    mem_if.mem_read_data = 32'd0;
    mem_if.mem_clk_stall = 1'b0;
    tick();
    tick();

    // ---- reset state ----
    check("rst_req_ready", 32'(core_if.req_ready),      32'd1);
    check("rst_rsp_valid", 32'(core_if.rsp_valid),      32'd0);
    check("rst_rsp_err",   32'(core_if.rsp_err),        32'd0);
    check("rst_rsp_data",  core_if.rsp_data,            32'd0);
    check("rst_memread",   32'(mem_if.mem_memread),     32'd0);
    check("rst_memwrite",  32'(mem_if.mem_memwrite),    32'd0);
    check("rst_mem_addr",  mem_if.mem_addr,             32'd0);
    check("rst_mask",      32'(mem_if.mem_sign_mask),   32'd0);
    rst_n = 1'b1;
    tick();

    // ---- SW 0x4 <- 0xff03ab21, zero stall ----
    check("sw_ready_before", 32'(core_if.req_ready), 32'd1);
    send(1'b1, 3'b010, 32'h4, 32'hff03ab21);
    check("sw_issue_memwrite", 32'(mem_if.mem_memwrite),  32'd1);
    check("sw_issue_memread",  32'(mem_if.mem_memread),   32'd0);
    check("sw_issue_mask",     32'(mem_if.mem_sign_mask), 32'h7);
    check("sw_issue_addr",     mem_if.mem_addr,           32'h4);
    check("sw_issue_wdata",    mem_if.mem_write_data,     32'hff03ab21);
    check("sw_issue_ready",    32'(core_if.req_ready),    32'd0);
    check("sw_issue_rspv",     32'(core_if.rsp_valid),    32'd0);
    tick();
    check("sw_wait_memwrite",  32'(mem_if.mem_memwrite),  32'd0);
    check("sw_wait_rspv",      32'(core_if.rsp_valid),    32'd0);
    check("sw_wait_addr",      mem_if.mem_addr,           32'h4);
    tick();
    check("sw_resp_valid",     32'(core_if.rsp_valid),    32'd1);
    check("sw_resp_err",       32'(core_if.rsp_err),      32'd0);
    check("sw_resp_data",      core_if.rsp_data,          32'd0);
    $display("rsp SW valid=%0d err=%0d data=%h", core_if.rsp_valid, core_if.rsp_err, core_if.rsp_data);
    finish_rsp("sw");

    // ---- LH 0x8, memory returns 0xffffab21, stall held for 4 cycles ----
    mem_if.mem_clk_stall = 1'b1;
    mem_if.mem_read_data = 32'hdeadbeef;
    send(1'b0, 3'b001, 32'h8, 32'h0);
    check("lh_issue_memread", 32'(mem_if.mem_memread),  32'd1);
    check("lh_issue_mask",    32'(mem_if.mem_sign_mask), 32'hb);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("lh_stall_memread", 32'(mem_if.mem_memread), 32'd0);
      check("lh_stall_rspv",    32'(core_if.rsp_valid),  32'd0);
      tick();
    end
    mem_if.mem_clk_stall = 1'b0;
    mem_if.mem_read_data = 32'hffffab21;
    tick();
    mem_if.mem_read_data = 32'hdeadbeef;
    check("lh_resp_valid", 32'(core_if.rsp_valid), 32'd1);
    check("lh_resp_data",  core_if.rsp_data,       32'hffffab21);
    check("lh_resp_err",   32'(core_if.rsp_err),   32'd0);
    $display("rsp LH valid=%0d err=%0d data=%h", core_if.rsp_valid, core_if.rsp_err, core_if.rsp_data);
    finish_rsp("lh");

    // ---- LBU 0x13 (0x53) with consumer back-pressure ----
    mem_if.mem_read_data = 32'h00000053;
    send(1'b0, 3'b100, 32'h13, 32'h0);
    check("lbu_issue_mask", 32'(mem_if.mem_sign_mask), 32'h1);
    check("lbu_issue_addr", mem_if.mem_addr,           32'h13);
    tick();
    tick();
    mem_if.mem_read_data = 32'hdeadbeef;
    for (int i = 0; i < 3; i++) begin
      check("lbu_hold_valid", 32'(core_if.rsp_valid), 32'd1);
      check("lbu_hold_data",  core_if.rsp_data,       32'h00000053);
      check("lbu_hold_err",   32'(core_if.rsp_err),   32'd0);
      check("lbu_hold_ready", 32'(core_if.req_ready), 32'd0);
      tick();
    end
    $display("rsp LBU valid=%0d err=%0d data=%h", core_if.rsp_valid, core_if.rsp_err, core_if.rsp_data);
    finish_rsp("lbu");

    // ---- illegal load funct3=011: error, no strobe ----
    send(1'b0, 3'b011, 32'h20, 32'h0);
    check("ill_ld_memread",  32'(mem_if.mem_memread),  32'd0);
    check("ill_ld_memwrite", 32'(mem_if.mem_memwrite), 32'd0);
    check("ill_ld_valid",    32'(core_if.rsp_valid),   32'd1);
    check("ill_ld_err",      32'(core_if.rsp_err),     32'd1);
    check("ill_ld_data",     core_if.rsp_data,         32'd0);
    $display("rsp ILL-LD valid=%0d err=%0d data=%h", core_if.rsp_valid, core_if.rsp_err, core_if.rsp_data);
    finish_rsp("ill_ld");
    check("ill_ld_err_clear", 32'(core_if.rsp_err), 32'd0);

    // ---- illegal store funct3=100 ----
    send(1'b1, 3'b100, 32'h24, 32'h12345678);
    check("ill_st_memwrite", 32'(mem_if.mem_memwrite), 32'd0);
    check("ill_st_err",      32'(core_if.rsp_err),     32'd1);
    $display("rsp ILL-ST valid=%0d err=%0d data=%h", core_if.rsp_valid, core_if.rsp_err, core_if.rsp_data);
    finish_rsp("ill_st");

    // ---- LH at odd address 0x5 ----
    mem_if.mem_read_data = 32'h00001234;
    send(1'b0, 3'b001, 32'h5, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_memread", 32'(mem_if.mem_memread), 32'd0);
    check("mis_valid",   32'(core_if.rsp_valid),  32'd1);
    check("mis_err",     32'(core_if.rsp_err),    32'd1);
    check("mis_data",    core_if.rsp_data,        32'd0);
`else
    check("mis_memread", 32'(mem_if.mem_memread), 32'd1);
    check("mis_addr",    mem_if.mem_addr,         32'h5);
    tick();
    tick();
    check("mis_valid",   32'(core_if.rsp_valid),  32'd1);
    check("mis_err",     32'(core_if.rsp_err),    32'd0);
    check("mis_data",    core_if.rsp_data,        32'h00001234);
`endif
    $display("rsp LH-0x5 valid=%0d err=%0d data=%h", core_if.rsp_valid, core_if.rsp_err, core_if.rsp_data);
    finish_rsp("mis");

    // ---- stall stuck high: watchdog fires after 8 WAIT cycles ----
    mem_if.mem_clk_stall = 1'b1;
    mem_if.mem_read_data = 32'hcafef00d;
    send(1'b0, 3'b010, 32'hc, 32'h0);
    check("to_issue_memread", 32'(mem_if.mem_memread), 32'd1);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("to_wait_rspv", 32'(core_if.rsp_valid), 32'd0);
      tick();
    end
    check("to_resp_valid", 32'(core_if.rsp_valid), 32'd1);
    check("to_resp_err",   32'(core_if.rsp_err),   32'd1);
    check("to_resp_data",  core_if.rsp_data,       32'd0);
    $display("rsp TIMEOUT valid=%0d err=%0d data=%h", core_if.rsp_valid, core_if.rsp_err, core_if.rsp_data);
    mem_if.mem_clk_stall = 1'b0;
    finish_rsp("to");

    // ---- reset asserted during WAIT of SW to 0x2000 ----
    mem_if.mem_clk_stall = 1'b1;
    send(1'b1, 3'b010, 32'h2000, 32'h5a5a5a5a);
    check("rstw_issue_memwrite", 32'(mem_if.mem_memwrite), 32'd1);
    tick();
    check("rstw_wait_addr", mem_if.mem_addr, 32'h2000);
    rst_n = 1'b0;
    #1;
    check("rstw_addr",      mem_if.mem_addr,           32'd0);
    check("rstw_wdata",     mem_if.mem_write_data,     32'd0);
    check("rstw_mask",      32'(mem_if.mem_sign_mask), 32'd0);
    check("rstw_memwrite",  32'(mem_if.mem_memwrite),  32'd0);
    check("rstw_req_ready", 32'(core_if.req_ready),    32'd1);
    check("rstw_rspv",      32'(core_if.rsp_valid),    32'd0);
    tick();
    mem_if.mem_clk_stall = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    check("rstw_after_rspv",     32'(core_if.rsp_valid),   32'd0);
    check("rstw_after_memwrite", 32'(mem_if.mem_memwrite), 32'd0);
    check("rstw_after_ready",    32'(core_if.req_ready),   32'd1);
    $display("rst-in-WAIT ready=%0d rsp_valid=%0d", core_if.req_ready, core_if.rsp_valid);

    // ---- recovery: LB 0x1 returns sign-extended 0x80 ----
    mem_if.mem_read_data = 32'hffffff80;
    send(1'b0, 3'b000, 32'h1, 32'h0);
    check("lb_issue_mask",    32'(mem_if.mem_sign_mask), 32'h9);
    check("lb_issue_memread", 32'(mem_if.mem_memread),   32'd1);
    tick();
    tick();
    check("lb_resp_data", core_if.rsp_data,     32'hffffff80);
    check("lb_resp_err",  32'(core_if.rsp_err), 32'd0);
    $display("rsp LB valid=%0d err=%0d data=%h", core_if.rsp_valid, core_if.rsp_err, core_if.rsp_data);
    finish_rsp("lb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
